denise_clut_wrctl: RTL and testbench

- Write-port controller for the 256-entry AGA colour lookup table RAM (32-bit word, 4 byte enables, 12-bit hi/lo nibble halves).
- Captures COLORxx register writes from the chip bus into a small FIFO.
- Runs a palette-clear sequencer after reset or on request, and arbitrates both sources onto the single RAM write port, at most one write per clk.
- Sits between the Denise register decode and the CLUT RAM instance; the read side is untouched.

---
 rtl/denise_clut_pkg.sv | 26 ++
 rtl/denise_clut_wrctl_if.sv | 26 ++
 rtl/denise_clut_wrfifo.sv | 55 +++++
 rtl/denise_clut_wrctl.sv | 129 ++++++++++++
 tb/tb_denise_clut_wrctl.sv | 359 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/denise_clut_pkg.sv
// Shared types and constants for the AGA colour lookup table write path.
package denise_clut_pkg;

    localparam logic [8:0] COLORBASE = 9'h180;
    localparam int         CLUT_AW   = 8;

    localparam logic [3:0] BS_ALL = 4'b1111;
    localparam logic [3:0] BS_LO  = 4'b0011;

    typedef struct packed {
        logic [CLUT_AW-1:0] adr;
        logic [11:0]        dat;
        logic               lo;
    } clut_entry_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_INIT = 1'b1
    } clr_state_t;

    // The 12-bit colour is replicated into both nibble halves of the RAM word.
    function automatic logic [31:0] pack_word(input logic [11:0] dat);
        return {4'b0000, dat, 4'b0000, dat};
    endfunction

endpackage

// File: rtl/denise_clut_wrctl_if.sv
// Register-bus capture inputs and CLUT RAM write port of the write controller.
interface denise_clut_wrctl_if;
    import denise_clut_pkg::*;

    logic               clk7_en;
    logic [8:1]         reg_address_in;
    logic [11:0]        data_in;
    logic [2:0]         bank;
    logic               loct;

    logic [CLUT_AW-1:0] wr_adr;
    logic               wr_en;
    logic [31:0]        wr_dat;
    logic [3:0]         wr_bs;

    modport master (
        output clk7_en, reg_address_in, data_in, bank, loct,
        input  wr_adr, wr_en, wr_dat, wr_bs
    );

    modport slave (
        input  clk7_en, reg_address_in, data_in, bank, loct,
        output wr_adr, wr_en, wr_dat, wr_bs
    );

endinterface

// File: rtl/denise_clut_wrfifo.sv
// Small synchronous FIFO buffering captured COLORxx writes until the RAM port is free.
module denise_clut_wrfifo
    import denise_clut_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        push,
    input  clut_entry_t push_data,
    input  logic        pop,
    output clut_entry_t head,
    output logic        full,
    output logic        empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    clut_entry_t   mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/denise_clut_wrctl.sv
// CLUT RAM write-port controller: buffers COLORxx bus writes and interleaves them
// with a palette-clear sweep, one RAM write per clk at most.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   ST_IDLE | palette clear finished; only buffered bus writes reach the RAM
//   ST_INIT | sweeping cnt 0..255 writing zero; yields to pending bus writes
module denise_clut_wrctl #(
    parameter int         DEPTH     = 4,
    parameter logic [8:0] COLORBASE = denise_clut_pkg::COLORBASE
) (
    input  logic                      clk,
    input  logic                      reset_n,
    denise_clut_wrctl_if.slave        bus,
    input  logic                      init_req,
    output logic                      init_busy,
    output logic                      ovf
);
    import denise_clut_pkg::*;

    clr_state_t         state;
    clr_state_t         state_nxt;
    logic [CLUT_AW-1:0] cnt;
    logic [CLUT_AW-1:0] cnt_nxt;
    logic               clr_issue;

    logic               cap_hit;
    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    clut_entry_t        cap_entry;
    clut_entry_t        fifo_head;

    logic               wr_en_q;
    logic [CLUT_AW-1:0] wr_adr_q;
    logic [31:0]        wr_dat_q;
    logic [3:0]         wr_bs_q;

    assign cap_hit   = bus.clk7_en && (bus.reg_address_in[8:6] == COLORBASE[8:6]);
    // A full FIFO never accepts, even when the head leaves on the same edge.
    assign fifo_push = cap_hit && !fifo_full;
    assign fifo_pop  = !fifo_empty;
    assign cap_entry = '{adr: {bus.bank, bus.reg_address_in[5:1]},
                         dat: bus.data_in,
                         lo:  bus.loct};

    denise_clut_wrfifo #(
        .DEPTH(DEPTH)
    ) u_wrfifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (fifo_push),
        .push_data (cap_entry),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_INIT;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        clr_issue = 1'b0;
        if (state == ST_INIT && !fifo_pop) begin
            clr_issue = 1'b1;
            cnt_nxt   = cnt + CLUT_AW'(1);
            if (cnt == '1) begin
                state_nxt = ST_IDLE;
            end
        end
        if (init_req) begin
            state_nxt = ST_INIT;
            cnt_nxt   = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_en_q  <= 1'b0;
            wr_adr_q <= '0;
            wr_dat_q <= '0;
            wr_bs_q  <= '0;
        end else if (fifo_pop) begin
            wr_en_q  <= 1'b1;
            wr_adr_q <= fifo_head.adr;
            wr_dat_q <= pack_word(fifo_head.dat);
            wr_bs_q  <= fifo_head.lo ? BS_LO : BS_ALL;
        end else if (clr_issue) begin
            wr_en_q  <= 1'b1;
            wr_adr_q <= cnt;
            wr_dat_q <= '0;
            wr_bs_q  <= BS_ALL;
        end else begin
            wr_en_q  <= 1'b0;
        end
    end

    // busy lags the state by one edge so it stays high while the last clear write is on the port
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            init_busy <= 1'b1;
            ovf       <= 1'b0;
        end else begin
            init_busy <= (state == ST_INIT);
            if (cap_hit && fifo_full) begin
                ovf <= 1'b1;
            end else if (init_req) begin
                ovf <= 1'b0;
            end
        end
    end

    assign bus.wr_en  = wr_en_q;
    assign bus.wr_adr = wr_adr_q;
    assign bus.wr_dat = wr_dat_q;
    assign bus.wr_bs  = wr_bs_q;

endmodule

// File: tb/tb_denise_clut_wrctl.sv
// Directed bench for the CLUT write controller with a byte-enable RAM shadow.
module tb_denise_clut_wrctl;

    logic clk       = 1'b0;
    logic reset_n   = 1'b0;
    logic init_req  = 1'b0;
    logic init_busy;
    logic ovf;

    int checks = 0;
    int errors = 0;

    logic [31:0] ram [256];

    denise_clut_wrctl_if bus_if ();

    denise_clut_wrctl #(
        .DEPTH(4),
        .COLORBASE(9'h180)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus_if.slave),
        .init_req  (init_req),
        .init_busy (init_busy),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus_if.wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (bus_if.wr_bs[b]) begin
                    ram[bus_if.wr_adr][b*8 +: 8] <= bus_if.wr_dat[b*8 +: 8];
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog expired");
    end

    task automatic drive_bus(input logic en, input logic [7:0] adr8, input logic [11:0] dat,
                             input logic [2:0] bk, input logic lo);
        bus_if.clk7_en        = en;
        bus_if.reg_address_in = adr8;
        bus_if.data_in        = dat;
        bus_if.bank           = bk;
        bus_if.loct           = lo;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic restart();
        reset_n  = 1'b0;
        init_req = 1'b0;
        drive_bus(1'b0, 8'h00, 12'h000, 3'd0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        drive_bus(1'b0, 8'h00, 12'h000, 3'd0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus_if.wr_en, bus_if.wr_adr, bus_if.wr_dat, bus_if.wr_bs} !== 45'd0) begin
            errors++;
            $display("FAIL reset_port: got en=%b adr=%h dat=%h bs=%h, want all zero",
                     bus_if.wr_en, bus_if.wr_adr, bus_if.wr_dat, bus_if.wr_bs);
        end
        checks++;
        if (init_busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_init_busy: got %b want 1", init_busy);
        end
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_ovf: got %b want 0", ovf);
        end
    endtask

    task automatic test_clear_full();
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 1; k <= 256; k++) begin
            step();
            checks++;
            if ({bus_if.wr_en, bus_if.wr_adr, bus_if.wr_dat, bus_if.wr_bs, init_busy} !==
                {1'b1, 8'(k-1), 32'h0, 4'hF, 1'b1}) begin
                errors++;
                $display("FAIL clear_full k=%0d: got en=%b adr=%h dat=%h bs=%h busy=%b, want en=1 adr=%h dat=0 bs=f busy=1",
                         k, bus_if.wr_en, bus_if.wr_adr, bus_if.wr_dat, bus_if.wr_bs, init_busy, 8'(k-1));
            end
        end
        step();
        checks++;
        if ({bus_if.wr_en, init_busy, bus_if.wr_adr} !== {1'b0, 1'b0, 8'hFF}) begin
            errors++;
            $display("FAIL clear_full_end: got en=%b busy=%b adr=%h, want en=0 busy=0 adr=ff",
                     bus_if.wr_en, init_busy, bus_if.wr_adr);
        end
    endtask

    task automatic test_clear_inject();
        logic [7:0]  ea;
        logic [31:0] ed;
        restart();
        for (int k = 1; k <= 257; k++) begin
            step();
            if (k <= 5) begin
                ea = 8'(k-1); ed = 32'h0;
            end else if (k == 6) begin
                ea = 8'h10;   ed = 32'h01230123;
            end else begin
                ea = 8'(k-2); ed = 32'h0;
            end
            checks++;
            if ({bus_if.wr_en, bus_if.wr_adr, bus_if.wr_dat, bus_if.wr_bs, init_busy} !==
                {1'b1, ea, ed, 4'hF, 1'b1}) begin
                errors++;
                $display("FAIL clear_inject k=%0d: got en=%b adr=%h dat=%h bs=%h busy=%b, want en=1 adr=%h dat=%h bs=f busy=1",
                         k, bus_if.wr_en, bus_if.wr_adr, bus_if.wr_dat, bus_if.wr_bs, init_busy, ea, ed);
            end
            if (k == 4) drive_bus(1'b1, 8'hD0, 12'h123, 3'd0, 1'b0);
            if (k == 5) drive_bus(1'b0, 8'h00, 12'h000, 3'd0, 1'b0);
            if (k == 10) begin
                checks++;
                if (ram[8'h10] !== 32'h01230123) begin
                    errors++;
                    $display("FAIL inject_ram_written: got %h want 01230123", ram[8'h10]);
                end
            end
        end
        step();
        checks++;
        if ({bus_if.wr_en, init_busy} !== 2'b00) begin
            errors++;
            $display("FAIL clear_inject_end: got en=%b busy=%b want 0 0", bus_if.wr_en, init_busy);
        end
        checks++;
        if (ram[8'h10] !== 32'h0) begin
            errors++;
            $display("FAIL inject_ram_cleared: got %h want 00000000", ram[8'h10]);
        end
    endtask

    task automatic test_capture();
        for (int v = 0; v < 2; v++) begin
            drive_bus(1'b1, 8'hC1, 12'hABC, 3'd2, 1'(v));
            step();
            drive_bus(1'b0, 8'h00, 12'h000, 3'd0, 1'b0);
            checks++;
            if (bus_if.wr_en !== 1'b0) begin
                errors++;
                $display("FAIL capture_latency v=%0d: got en=%b want 0", v, bus_if.wr_en);
            end
            step();
            checks++;
            if ({bus_if.wr_en, bus_if.wr_adr, bus_if.wr_dat, bus_if.wr_bs} !==
                {1'b1, 8'h41, 32'h0ABC0ABC, (v == 1) ? 4'h3 : 4'hF}) begin
                errors++;
                $display("FAIL capture_write v=%0d: got en=%b adr=%h dat=%h bs=%h, want en=1 adr=41 dat=0abc0abc bs=%h",
                         v, bus_if.wr_en, bus_if.wr_adr, bus_if.wr_dat, bus_if.wr_bs, (v == 1) ? 4'h3 : 4'hF);
            end
            step();
            checks++;
            if ({bus_if.wr_en, bus_if.wr_adr, bus_if.wr_dat} !== {1'b0, 8'h41, 32'h0ABC0ABC}) begin
                errors++;
                $display("FAIL capture_hold v=%0d: got en=%b adr=%h dat=%h, want en=0 adr=41 dat=0abc0abc",
                         v, bus_if.wr_en, bus_if.wr_adr, bus_if.wr_dat);
            end
        end
        // outside the colour block, then inside it without the 7MHz enable
        for (int v = 0; v < 2; v++) begin
            if (v == 0) drive_bus(1'b1, 8'h80, 12'h555, 3'd1, 1'b0);
            else        drive_bus(1'b0, 8'hC2, 12'h555, 3'd1, 1'b0);
            step();
            drive_bus(1'b0, 8'h00, 12'h000, 3'd0, 1'b0);
            for (int c = 0; c < 2; c++) begin
                step();
                checks++;
                if (bus_if.wr_en !== 1'b0) begin
                    errors++;
                    $display("FAIL capture_nomatch v=%0d c=%0d: got en=%b want 0", v, c, bus_if.wr_en);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  ra [3];
        logic [11:0] rd [3];
        logic [2:0]  rb [3];
        logic        rl [3];
        logic [7:0]  xa [3];
        logic [31:0] xd [3];
        logic [3:0]  xb [3];
        ra = '{8'hC0, 8'hDF, 8'hC5};
        rd = '{12'h001, 12'hFFF, 12'h5A5};
        rb = '{3'd0, 3'd7, 3'd5};
        rl = '{1'b0, 1'b1, 1'b0};
        xa = '{8'h00, 8'hFF, 8'hA5};
        xd = '{32'h00010001, 32'h0FFF0FFF, 32'h05A505A5};
        xb = '{4'hF, 4'h3, 4'hF};
        for (int i = 0; i < 4; i++) begin
            if (i < 3) drive_bus(1'b1, ra[i], rd[i], rb[i], rl[i]);
            else       drive_bus(1'b0, 8'h00, 12'h000, 3'd0, 1'b0);
            step();
            if (i >= 1) begin
                checks++;
                if ({bus_if.wr_en, bus_if.wr_adr, bus_if.wr_dat, bus_if.wr_bs} !==
                    {1'b1, xa[i-1], xd[i-1], xb[i-1]}) begin
                    errors++;
                    $display("FAIL back_to_back i=%0d: got en=%b adr=%h dat=%h bs=%h, want en=1 adr=%h dat=%h bs=%h",
                             i-1, bus_if.wr_en, bus_if.wr_adr, bus_if.wr_dat, bus_if.wr_bs, xa[i-1], xd[i-1], xb[i-1]);
                end
            end
        end
        step();
        checks++;
        if (bus_if.wr_en !== 1'b0) begin
            errors++;
            $display("FAIL back_to_back_idle: got en=%b want 0", bus_if.wr_en);
        end
    endtask

    task automatic test_overflow();
        logic [11:0] d;
        force dut.fifo_pop = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive_bus(1'b1, 8'(8'hC1 + i), 12'(12'h100 + i), 3'd0, 1'b0);
            step();
            checks++;
            if ({bus_if.wr_en, ovf} !== {1'b0, (i == 4)}) begin
                errors++;
                $display("FAIL overflow_fill i=%0d: got en=%b ovf=%b, want en=0 ovf=%b",
                         i, bus_if.wr_en, ovf, (i == 4));
            end
        end
        drive_bus(1'b0, 8'h00, 12'h000, 3'd0, 1'b0);
        release dut.fifo_pop;
        for (int j = 0; j < 4; j++) begin
            step();
            d = 12'(12'h100 + j);
            checks++;
            if ({bus_if.wr_en, bus_if.wr_adr, bus_if.wr_dat, bus_if.wr_bs} !==
                {1'b1, 8'(j + 1), 4'h0, d, 4'h0, d, 4'hF}) begin
                errors++;
                $display("FAIL overflow_drain j=%0d: got en=%b adr=%h dat=%h bs=%h, want en=1 adr=%h dat=0%h0%h bs=f",
                         j, bus_if.wr_en, bus_if.wr_adr, bus_if.wr_dat, bus_if.wr_bs, 8'(j + 1), d, d);
            end
        end
        step();
        checks++;
        if ({bus_if.wr_en, ovf} !== 2'b01) begin
            errors++;
            $display("FAIL overflow_lost: got en=%b ovf=%b, want en=0 ovf=1", bus_if.wr_en, ovf);
        end
        init_req = 1'b1;
        step();
        init_req = 1'b0;
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL overflow_clear: got ovf=%b want 0", ovf);
        end
        step();
        checks++;
        if ({bus_if.wr_en, bus_if.wr_adr, bus_if.wr_dat} !== {1'b1, 8'h00, 32'h0}) begin
            errors++;
            $display("FAIL init_from_idle: got en=%b adr=%h dat=%h, want en=1 adr=00 dat=0",
                     bus_if.wr_en, bus_if.wr_adr, bus_if.wr_dat);
        end
        // overflow coinciding with init_req: the set must win
        force dut.fifo_pop = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive_bus(1'b1, 8'hC7, 12'h777, 3'd3, 1'b0);
            if (i == 4) init_req = 1'b1;
            step();
        end
        init_req = 1'b0;
        drive_bus(1'b0, 8'h00, 12'h000, 3'd0, 1'b0);
        release dut.fifo_pop;
        checks++;
        if (ovf !== 1'b1) begin
            errors++;
            $display("FAIL overflow_set_wins: got ovf=%b want 1", ovf);
        end
    endtask

    task automatic test_init_restart();
        logic [7:0] ea;
        restart();
        for (int k = 1; k <= 385; k++) begin
            step();
            ea = (k <= 129) ? 8'(k-1) : 8'(k-130);
            checks++;
            if ({bus_if.wr_en, bus_if.wr_adr, bus_if.wr_dat, bus_if.wr_bs} !== {1'b1, ea, 32'h0, 4'hF}) begin
                errors++;
                $display("FAIL init_restart k=%0d: got en=%b adr=%h dat=%h bs=%h, want en=1 adr=%h dat=0 bs=f",
                         k, bus_if.wr_en, bus_if.wr_adr, bus_if.wr_dat, bus_if.wr_bs, ea);
            end
            if (k == 128) init_req = 1'b1;
            if (k == 129) init_req = 1'b0;
        end
        step();
        checks++;
        if ({bus_if.wr_en, init_busy} !== 2'b00) begin
            errors++;
            $display("FAIL init_restart_end: got en=%b busy=%b want 0 0", bus_if.wr_en, init_busy);
        end
        init_req = 1'b1;
        step();
        init_req = 1'b0;
        repeat (20) step();
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({bus_if.wr_en, bus_if.wr_adr, bus_if.wr_dat, bus_if.wr_bs, init_busy, ovf} !==
            {1'b0, 8'h00, 32'h0, 4'h0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL async_reset: got en=%b adr=%h dat=%h bs=%h busy=%b ovf=%b, want 0 00 0 0 1 0",
                     bus_if.wr_en, bus_if.wr_adr, bus_if.wr_dat, bus_if.wr_bs, init_busy, ovf);
        end
        @(negedge clk);
        reset_n = 1'b1;
        step();
        checks++;
        if ({bus_if.wr_en, bus_if.wr_adr} !== {1'b1, 8'h00}) begin
            errors++;
            $display("FAIL reset_restart: got en=%b adr=%h, want en=1 adr=00", bus_if.wr_en, bus_if.wr_adr);
        end
    endtask

    initial begin
        test_reset();
        test_clear_full();
        test_clear_inject();
        test_capture();
        test_back_to_back();
        test_overflow();
        test_init_restart();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
